// File: rtl/mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl
// Memory-access stage controller sitting between EX and the WB mux.
// Accepts one request at a time, decodes the region select, services it from
// an internal byte-writable DMEM (1-cycle latency) or an external wait-stated
// narrow ROM (ROM_LAT+1 cycles), and returns an extended word plus error flag.
//
// Handshake: a request is taken when req_valid & req_ready are both high at a
// rising edge; a response is retired when rsp_valid & rsp_ready are both high
// at a rising edge. Only one request is outstanding; req_ready is high only in
// IDLE, and rsp_valid/rsp_rdata/rsp_err stay stable until retired.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready request handshake
//   req_we, req_sel     write enable, region (0 DMEM, 1 ROM, 2/3 reserved)
//   req_addr            word address
//   req_wdata, req_be   DMEM write data and byte enables
//   rsp_valid/rsp_ready response handshake
//   rsp_rdata, rsp_err  read data (0 on writes/errors), reject flag
//   rom_en, rom_addr    external ROM enable and registered address
//   rom_data            external ROM read data
//   dbg_state           current FSM state (0 IDLE, 1 ROM_WAIT, 2 RESP)
// -----------------------------------------------------------------------------
module mem_stage_ctrl #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int DMEM_DEPTH = 1024,
  parameter int ROM_W      = 16,
  parameter int ROM_AW     = 19,
  parameter int ROM_LAT    = 2,
  parameter int ROM_SEXT   = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_sel,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rom_en,
  output logic [ROM_AW-1:0]   rom_addr,
  input  logic [ROM_W-1:0]    rom_data,
  output logic [1:0]          dbg_state
);

  localparam int BE_W   = DATA_W / 8;
  localparam int DIDX_W = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;
  localparam int CNT_W  = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ROM_WAIT = 2'd1,
    S_RESP     = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  mem [DMEM_DEPTH];
  logic [DATA_W-1:0]  rom_ext;

  logic               accept;
  logic               dmem_oob;
  logic               req_ok;
  logic               dmem_wr;
  logic               dmem_rd;
  logic               rom_go;
  logic [DIDX_W-1:0]  dmem_idx;

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign dbg_state = state;

  // Request decode; only meaningful in the accept cycle.
  assign accept   = req_valid & req_ready;
  assign dmem_oob = (req_addr >= ADDR_W'(DMEM_DEPTH));
  assign req_ok   = ((req_sel == 2'd0) & ~dmem_oob) | ((req_sel == 2'd1) & ~req_we);
  assign dmem_wr  = accept & (req_sel == 2'd0) & ~dmem_oob &  req_we;
  assign dmem_rd  = accept & (req_sel == 2'd0) & ~dmem_oob & ~req_we;
  assign rom_go   = accept & (req_sel == 2'd1) & ~req_we;
  assign dmem_idx = req_addr[DIDX_W-1:0];

  // Fill the whole word with the extension bit, then overlay the ROM bits;
  // this stays legal when ROM_W == DATA_W.
  always_comb begin
    rom_ext = {DATA_W{(ROM_SEXT != 0) & rom_data[ROM_W-1]}};
    rom_ext[ROM_W-1:0] = rom_data;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (accept) state_nxt = rom_go ? S_ROM_WAIT : S_RESP;
      S_ROM_WAIT: if (cnt == '0) state_nxt = S_RESP;
      S_RESP:     if (rsp_ready) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // State register and response/ROM datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      rom_en    <= 1'b0;
      rom_addr  <= '0;
      cnt       <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (accept) begin
            rsp_err   <= ~req_ok;
            rsp_rdata <= dmem_rd ? mem[dmem_idx] : '0;
            if (rom_go) begin
              rom_en   <= 1'b1;
              rom_addr <= req_addr[ROM_AW-1:0];
              cnt      <= CNT_W'(ROM_LAT - 1);
            end
          end
        end
        S_ROM_WAIT: begin
          if (cnt == '0) begin
            rsp_rdata <= rom_ext;
            rom_en    <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // DMEM storage is deliberately not reset so data survives a pipeline reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (dmem_wr && req_be[i]) begin
        mem[dmem_idx][i*8 +: 8] <= req_wdata[i*8 +: 8];
      end
    end
  end

endmodule
